// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//
// Host-side framer feeding the write side of the UART transmit FIFO. Each
// message goes out as: SOF byte, length byte, payload bytes, XOR checksum.
// The checksum covers the length byte and every payload byte (not SOF).
// FIFO back-pressure (tx_full) is honoured on every byte, so nothing is
// dropped or repeated.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   start      frame request, only looked at in IDLE
//   len        payload byte count, captured together with start
//   pl_data    payload byte from the producer
//   pl_valid   pl_data is valid
//   pl_ready   framer takes pl_data this cycle (only ever high in DATA)
//   tx_full    UART TX FIFO is full
//   wr_uart    FIFO write strobe, one byte per high cycle
//   w_data     byte presented to the FIFO
//   busy       framer is in any state other than IDLE
//   done_tick  one-cycle pulse once the checksum byte has been written
//   err_len    one-cycle pulse after a start with len of 0 or above MAX_LEN
// -----------------------------------------------------------------------------
module uart_frame_tx #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         LEN_BIT = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_BIT-1:0] len,
    input  logic [7:0]         pl_data,
    input  logic               pl_valid,
    output logic               pl_ready,
    input  logic               tx_full,
    output logic               wr_uart,
    output logic [7:0]         w_data,
    output logic               busy,
    output logic               done_tick,
    output logic               err_len
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SOF  = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [LEN_BIT-1:0] MAX_LEN_V = LEN_BIT'(MAX_LEN);
    localparam logic [LEN_BIT-1:0] ONE_V     = LEN_BIT'(1);

    logic [2:0]         state_reg;
    logic [LEN_BIT-1:0] len_reg;
    logic [LEN_BIT-1:0] cnt_reg;
    logic [7:0]         csum_reg;
    logic               done_reg;
    logic               err_reg;

    logic               write_cond;
    logic               len_ok;
    logic               last_byte;

    assign len_ok    = (len != '0) && (len <= MAX_LEN_V);
    assign last_byte = (cnt_reg == len_reg - ONE_V);

    // Byte selection and write qualification. A transfer in DATA is exactly
    // a FIFO write, so pl_ready simply mirrors FIFO space in that state.
    always_comb begin
        // NOTE: every output of this block gets a default up front so that no
        // path through the case statement leaves one unassigned (no latches).
        write_cond = 1'b0;
        w_data     = 8'h00;
        pl_ready   = 1'b0;
        case (state_reg)
            ST_SOF: begin
                write_cond = 1'b1;
                w_data     = SOF;
            end
            ST_LEN: begin
                write_cond = 1'b1;
                w_data     = 8'(len_reg);
            end
            ST_DATA: begin
                write_cond = pl_valid;
                w_data     = pl_data;
                pl_ready   = !tx_full;
            end
            ST_CSUM: begin
                write_cond = 1'b1;
                w_data     = csum_reg;
            end
            default: ;
        endcase
    end

    assign wr_uart   = write_cond && !tx_full;
    assign busy      = (state_reg != ST_IDLE);
    assign done_tick = done_reg;
    assign err_len   = err_reg;

    // Every state other than IDLE/DONE advances only on a cycle that actually
    // wrote a byte, which is what makes tx_full stalls lossless.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that all
        // registers update together from values sampled before the edge.
        if (!reset) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            cnt_reg   <= '0;
            csum_reg  <= 8'h00;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_reg   <= len;
                            cnt_reg   <= '0;
                            csum_reg  <= 8'h00;
                            state_reg <= ST_SOF;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_SOF: begin
                    if (wr_uart) state_reg <= ST_LEN;
                end
                ST_LEN: begin
                    if (wr_uart) begin
                        csum_reg  <= 8'(len_reg);
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_uart) begin
                        csum_reg <= csum_reg ^ pl_data;
                        if (last_byte) begin
                            cnt_reg   <= '0;
                            state_reg <= ST_CSUM;
                        end else begin
                            cnt_reg <= cnt_reg + ONE_V;
                        end
                    end
                end
                ST_CSUM: begin
                    if (wr_uart) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A start arriving here is deliberately dropped.
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
